// File: rtl/ofdm_dac_pkg.sv
// Shared types and arithmetic for the OFDM DAC formatter.
// Latency: n/a (types, constants and pure combinational functions).
// Backpressure: n/a.
package ofdm_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic FMT_TWOS   = 1'b0;
    localparam logic FMT_OFFSET = 1'b1;

    // Code that represents "zero signal" on the DAC: mid-scale in offset-binary.
    function automatic logic [31:0] idle_code(input logic fmt, input int dac_w);
        logic [31:0] c;
        c = '0;
        if (fmt == FMT_OFFSET) begin
            c = 32'd1 << (dac_w - 1);
        end
        return c;
    endfunction

    // Round half up, drop SH = in_w - dac_w LSBs, saturate to the signed DAC range,
    // then optionally flip the MSB to turn two's complement into offset-binary.
    // The sum is kept two bits wider than the sign-extended input so the rounding
    // constant can never overflow it.
    function automatic logic [31:0] round_sat_fmt(input logic signed [31:0] x,
                                                  input int in_w,
                                                  input int dac_w,
                                                  input logic fmt);
        int                 sh;
        logic signed [33:0] t;
        logic signed [33:0] v;
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        logic [31:0]        r;
        sh = in_w - dac_w;
        t  = 34'(x) + (34'sd1 <<< (sh - 1));
        v  = t >>> sh;
        hi = (34'sd1 <<< (dac_w - 1)) - 34'sd1;
        lo = -(34'sd1 <<< (dac_w - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        r = 32'(v) & ((32'd1 << dac_w) - 32'd1);
        if (fmt == FMT_OFFSET) begin
            r = r ^ (32'd1 << (dac_w - 1));
        end
        return r;
    endfunction

endpackage

// File: rtl/ofdm_sample_fifo.sv
// Synchronous sample FIFO with flush and occupancy output (read data is the head, combinational).
// Latency: a pushed word is visible at the head the clock after the push when the FIFO was empty.
// Backpressure: none internally; the caller must not push when full (unless popping) or pop when empty.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the FIFO (wins over push);
//        push_i/wr_dat_i write; pop_i/rd_dat_o read; level_o occupancy 0..DEPTH.
module ofdm_sample_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wr_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rd_dat_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid. A push while
    // full and popping writes the slot being read, whose old value is still seen
    // on rd_dat_o until the edge.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign level_o  = level_q;

endmodule

// File: rtl/ofdm_dac_formatter.sv
// Buffers complex samples and replays them to the DAC at one sample per RATE_DIV clocks, rounded,
// saturated and coded as two's complement or offset-binary. Latency: popped sample on dac_* 1 clk after its tick.
// Backpressure: in_ready_o low in IDLE, when disabled, and when full unless that cycle also pops.
// Ports: clk_i, rst_ni (async, active low); enable_i run/flush; fmt_offset_i latched on leaving IDLE;
//        in_valid_i/in_ready_o/in_re_i/in_im_i sample input; dac_i_o/dac_q_o/dac_strobe_o registered DAC side;
//        underrun_o pulse and urun_cnt_o saturating count; fifo_level_o occupancy.
module ofdm_dac_formatter
    import ofdm_dac_pkg::*;
#(
    parameter int IN_W       = 18,
    parameter int DAC_W      = 16,
    parameter int RATE_DIV   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int PRIME_LVL  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          fmt_offset_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic signed [IN_W-1:0]        in_re_i,
    input  logic signed [IN_W-1:0]        in_im_i,
    output logic [DAC_W-1:0]              dac_i_o,
    output logic [DAC_W-1:0]              dac_q_o,
    output logic                          dac_strobe_o,
    output logic                          underrun_o,
    output logic [15:0]                   urun_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(RATE_DIV);
    localparam int DW    = 2 * IN_W;

    state_e             state_q;
    logic               fmt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DAC_W-1:0]   dac_re_q;
    logic [DAC_W-1:0]   dac_im_q;
    logic               strobe_q;
    logic               urun_q;
    logic [15:0]        urun_cnt_q;

    logic               tick;
    logic               empty;
    logic               full;
    logic               primed;
    logic               pop;
    logic               push;
    logic               flush;
    logic [LVL_W-1:0]   level;
    logic [DW-1:0]      rd_dat;
    logic signed [IN_W-1:0] pop_re;
    logic signed [IN_W-1:0] pop_im;
    logic [DAC_W-1:0]   dac_re_d;
    logic [DAC_W-1:0]   dac_im_d;
    logic [DAC_W-1:0]   idle_cur;
    logic [DAC_W-1:0]   idle_new;

    // Strobe generator: one tick every RATE_DIV clocks, phase restarts on enable.
    assign tick = enable_i && (cnt_q == CNT_W'(RATE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable_i || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign empty  = (level == '0);
    assign full   = (level == LVL_W'(FIFO_DEPTH));
    assign primed = (level >= LVL_W'(PRIME_LVL));

    // The PRIME->RUN tick already takes the first sample.
    assign pop = tick && (((state_q == ST_PRIME) && primed) || ((state_q == ST_RUN) && !empty));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts on a tick.
    assign in_ready_o = enable_i && (state_q != ST_IDLE) && (!full || pop);
    assign push       = in_valid_i && in_ready_o;
    assign flush      = !enable_i || (state_q == ST_IDLE);

    ofdm_sample_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush),
        .push_i   (push),
        .wr_dat_i ({in_re_i, in_im_i}),
        .pop_i    (pop),
        .rd_dat_o (rd_dat),
        .level_o  (level)
    );

    assign pop_re   = rd_dat[DW-1:IN_W];
    assign pop_im   = rd_dat[IN_W-1:0];
    assign dac_re_d = DAC_W'(round_sat_fmt(32'(pop_re), IN_W, DAC_W, fmt_q));
    assign dac_im_d = DAC_W'(round_sat_fmt(32'(pop_im), IN_W, DAC_W, fmt_q));
    assign idle_cur = DAC_W'(idle_code(fmt_q, DAC_W));
    assign idle_new = DAC_W'(idle_code(fmt_offset_i, DAC_W));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            fmt_q      <= FMT_TWOS;
            dac_re_q   <= '0;
            dac_im_q   <= '0;
            strobe_q   <= 1'b0;
            urun_q     <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            urun_q   <= 1'b0;
            if (!enable_i) begin
                state_q  <= ST_IDLE;
                dac_re_q <= idle_cur;
                dac_im_q <= idle_cur;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Output format is frozen from here until the next IDLE.
                        fmt_q    <= fmt_offset_i;
                        state_q  <= ST_PRIME;
                        dac_re_q <= idle_new;
                        dac_im_q <= idle_new;
                    end
                    ST_PRIME: begin
                        if (tick) begin
                            strobe_q <= 1'b1;
                            if (primed) begin
                                state_q  <= ST_RUN;
                                dac_re_q <= dac_re_d;
                                dac_im_q <= dac_im_d;
                            end else begin
                                dac_re_q <= idle_cur;
                                dac_im_q <= idle_cur;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            strobe_q <= 1'b1;
                            if (!empty) begin
                                dac_re_q <= dac_re_d;
                                dac_im_q <= dac_im_d;
                            end else begin
                                dac_re_q <= idle_cur;
                                dac_im_q <= idle_cur;
                                urun_q   <= 1'b1;
                                state_q  <= ST_PRIME;
                                if (urun_cnt_q != 16'hFFFF) begin
                                    urun_cnt_q <= urun_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign dac_i_o      = dac_re_q;
    assign dac_q_o      = dac_im_q;
    assign dac_strobe_o = strobe_q;
    assign underrun_o   = urun_q;
    assign urun_cnt_o   = urun_cnt_q;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_ofdm_dac_formatter.sv
// Randomized scoreboard bench for ofdm_dac_formatter with a sample-queue reference model.
// Latency: n/a. Backpressure: stimulus respects in_ready for directed sends; random traffic relies on the model.
module tb_ofdm_dac_formatter;
    localparam int IN_W      = 18;
    localparam int DAC_W     = 16;
    localparam int RATE_DIV  = 2;
    localparam int DEPTH     = 8;
    localparam int PRIME_LVL = 4;
    localparam int SH        = IN_W - DAC_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   enable;
    logic                   fmt_offset;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_re;
    logic signed [IN_W-1:0] in_im;
    logic [DAC_W-1:0]       dac_i;
    logic [DAC_W-1:0]       dac_q;
    logic                   dac_strobe;
    logic                   underrun;
    logic [15:0]            urun_cnt;
    logic [$clog2(DEPTH):0] fifo_level;

    ofdm_dac_formatter #(
        .IN_W(IN_W), .DAC_W(DAC_W), .RATE_DIV(RATE_DIV), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fmt_offset_i(fmt_offset),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_re_i(in_re), .in_im_i(in_im),
        .dac_i_o(dac_i), .dac_q_o(dac_q), .dac_strobe_o(dac_strobe), .underrun_o(underrun),
        .urun_cnt_o(urun_cnt), .fifo_level_o(fifo_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_PRIME, M_RUN} mstate_t;
    typedef struct { int di; int dq; bit ur; } exp_t;

    mstate_t            m_state = M_IDLE;
    int                 m_phase = 0;   // enabled clocks since enable last rose
    logic [2*IN_W-1:0]  m_fifo[$];
    bit                 m_fmt   = 1'b0;
    int                 m_di    = 0;
    int                 m_dq    = 0;
    int                 m_ucnt  = 0;
    exp_t               exp_q[$];

    function automatic int idle_val(input bit offs);
        return offs ? (1 << (DAC_W - 1)) : 0;
    endfunction

    // Rounded value = floor((x + 2^(SH-1)) / 2^SH), clipped to the signed DAC range,
    // then shown either as a DAC_W-bit two's-complement word or biased by half scale.
    function automatic int ref_code(input int x, input bit offs);
        int t, v, d, maxv, minv;
        d    = 1 << SH;
        t    = x + d / 2;
        v    = (t >= 0) ? t / d : -((-t + d - 1) / d);
        maxv = (1 << (DAC_W - 1)) - 1;
        minv = -(1 << (DAC_W - 1));
        if (v > maxv) v = maxv;
        if (v < minv) v = minv;
        return offs ? v + (1 << (DAC_W - 1)) : (v & ((1 << DAC_W) - 1));
    endfunction

    // Model advances on the falling edge using the inputs that the next rising edge will see.
    always @(negedge clk) begin : model
        bit                     tick, pop, rdy, ur;
        int                     lvl;
        logic [2*IN_W-1:0]      s;
        logic signed [IN_W-1:0] sr, si;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_phase = 0;
            m_fifo.delete();
            m_fmt   = 1'b0;
            m_di    = 0;
            m_dq    = 0;
            m_ucnt  = 0;
            exp_q.delete();
        end else begin
            lvl  = m_fifo.size();
            tick = enable && ((m_phase % RATE_DIV) == RATE_DIV - 1);
            pop  = tick && ((m_state == M_PRIME && lvl >= PRIME_LVL) || (m_state == M_RUN && lvl > 0));
            rdy  = enable && (m_state != M_IDLE) && (lvl < DEPTH || pop);
            check("in_ready", in_ready, rdy);
            m_phase = enable ? m_phase + 1 : 0;
            if (!enable) begin
                m_state = M_IDLE;
                m_fifo.delete();
                m_di = idle_val(m_fmt);
                m_dq = idle_val(m_fmt);
            end else if (m_state == M_IDLE) begin
                m_fmt   = fmt_offset;
                m_state = M_PRIME;
                m_di    = idle_val(m_fmt);
                m_dq    = idle_val(m_fmt);
            end else begin
                if (tick) begin
                    ur = 1'b0;
                    if (pop) begin
                        s       = m_fifo.pop_front();
                        sr      = s[2*IN_W-1:IN_W];
                        si      = s[IN_W-1:0];
                        m_di    = ref_code(int'(sr), m_fmt);
                        m_dq    = ref_code(int'(si), m_fmt);
                        m_state = M_RUN;
                    end else begin
                        m_di = idle_val(m_fmt);
                        m_dq = idle_val(m_fmt);
                        if (m_state == M_RUN) begin
                            ur      = 1'b1;
                            m_state = M_PRIME;
                            if (m_ucnt < 65535) m_ucnt++;
                        end
                    end
                    exp_q.push_back('{m_di, m_dq, ur});
                end
                if (in_valid && rdy) m_fifo.push_back({in_re, in_im});
            end
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (dac_strobe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dac_i", dac_i, e.di);
                check("dac_q", dac_q, e.dq);
                check("underrun", underrun, e.ur);
            end
        end else begin
            check("missing_strobe", exp_q.size(), 0);
            exp_q.delete();
            check("hold_dac_i", dac_i, m_di);
            check("hold_dac_q", dac_q, m_dq);
            check("underrun_idle", underrun, 0);
        end
        check("fifo_level", fifo_level, m_fifo.size());
        check("urun_cnt", urun_cnt, m_ucnt);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [IN_W-1:0] r, input logic [IN_W-1:0] i);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_re    = r;
        in_im    = i;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    function automatic logic [IN_W-1:0] pick();
        logic [IN_W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 18'h1FFFF;
            1:       v = 18'h20000;
            2:       v = 18'h1FFFE;
            3:       v = 18'h00002;
            4:       v = 18'h3FFFE;
            default: v = IN_W'($urandom);
        endcase
        return v;
    endfunction

    logic [IN_W-1:0] dir_vals [5];

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        fmt_offset = 1'b0;
        in_valid   = 1'b0;
        in_re      = '0;
        in_im      = '0;
        dir_vals   = '{18'h1FFFF, 18'h20000, 18'h00000, 18'h00002, 18'h00001};
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Offset-binary playout of rounding/saturation corner values, then drain into underrun.
        fmt_offset = 1'b1;
        enable     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(dir_vals[k], pick());
            if (k == 1) fmt_offset = 1'b0;   // must not change the active format
        end
        repeat (20) cyc();
        // Refill after the underrun so playout resumes.
        for (int k = 0; k < 6; k++) send(pick(), pick());
        repeat (20) cyc();

        // Alternating saturating / sparse traffic, format toggles, enable drops with a full FIFO.
        for (int seg = 0; seg < 12; seg++) begin
            for (int c = 0; c < 40; c++) begin
                in_valid = (seg % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                in_re    = pick();
                in_im    = pick();
                if ($urandom_range(0, 15) == 0) fmt_offset = 1'($urandom);
                cyc();
            end
            if (seg % 2 == 0) begin
                in_valid = 1'b0;
                enable   = 1'b0;
                cyc();
                enable   = 1'b1;
            end
        end

        // Asynchronous reset in the middle of playout.
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1;
            in_re    = pick();
            in_im    = pick();
            cyc();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_dac_i", dac_i, 0);
        check("rst_dac_q", dac_q, 0);
        check("rst_strobe", dac_strobe, 0);
        check("rst_underrun", underrun, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_urun_cnt", urun_cnt, 0);
        in_valid = 1'b0;
        enable   = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
